// File: rtl/commit_trace_queue.sv
// commit_trace_queue: first-word-fall-through queue of retired-instruction
// records between the commit stage and the difftest reporting stage.
// It counts delivered records and keeps a sticky flag for dropped ones.
module commit_trace_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_pc,
   input  logic [31:0]   in_nextpc,
   input  logic [31:0]   in_inst,
   input  logic          out_ready,
   output logic          dpi_valid,
   output logic [31:0]   pc,
   output logic [31:0]   nextpc,
   output logic [31:0]   inst,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic [31:0]   commit_cnt
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [31:0]   pc_mem_q     [DEPTH];
   logic [31:0]   nextpc_mem_q [DEPTH];
   logic [31:0]   inst_mem_q   [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [31:0]   commit_cnt_q, commit_cnt_d;
   logic          push, pop;

   // Handshake decode: ready/valid come from registered occupancy only, so a
   // pop in the full cycle cannot open the input the same cycle.
   always_comb begin
      in_ready  = (count_q < FULL_CNT);
      dpi_valid = (count_q != '0);
      push      = in_valid & in_ready;
      pop       = dpi_valid & out_ready;
   end

   // Next-state for pointers, occupancy, drop flag and delivered-record counter.
   always_comb begin
      wr_ptr_d     = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d      = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      overflow_d   = overflow_q | (in_valid & ~in_ready);
      commit_cnt_d = pop ? commit_cnt_q + 32'd1 : commit_cnt_q;
   end

   // Control state; asynchronous reset discards everything buffered at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         commit_cnt_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         commit_cnt_q <= commit_cnt_d;
      end
   end

   // Record storage; contents are don't-care until the occupancy covers them.
   always_ff @(posedge clock) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]     <= in_pc;
         nextpc_mem_q[wr_ptr_q] <= in_nextpc;
         inst_mem_q[wr_ptr_q]   <= in_inst;
      end
   end

   // Head record fall-through, zeroed when empty so no stale data leaks out.
   always_comb begin
      pc         = dpi_valid ? pc_mem_q[rd_ptr_q]     : 32'd0;
      nextpc     = dpi_valid ? nextpc_mem_q[rd_ptr_q] : 32'd0;
      inst       = dpi_valid ? inst_mem_q[rd_ptr_q]   : 32'd0;
      count      = count_q;
      overflow   = overflow_q;
      commit_cnt = commit_cnt_q;
   end

endmodule
